// File: rtl/vga_pkg.sv
// Shared constants for the 640x480@60 raster: default segment sizes, derived totals
// and the v_count code used during vertical blanking.
package vga_pkg;

  localparam int DEF_CLK_DIV   = 4;
  localparam int DEF_H_ACTIVE  = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_ACTIVE  = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_ALIGN_LAT = 1;

  function automatic int seg_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int H_TOTAL = seg_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int V_TOTAL = seg_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  localparam logic [8:0] V_BLANK_CODE = 9'h1FF;

endpackage

// File: rtl/vga_sync_delay.sv
// Reset-valued clk-rate shift register that lines sync/de up with the overlay ROM read.
// Latency DEPTH clk cycles (DEPTH >= 1); no backpressure.
module vga_sync_delay #(
  parameter int               DEPTH   = 1,
  parameter int               WIDTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: pixel-rate divider, h/v position counters, sync and data-enable.
// Define VGA_TIMING_ALIGN_EN to delay hsync/vsync/de by ALIGN_LAT clk cycles.
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int ALIGN_LAT = DEF_ALIGN_LAT
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_tick,
  output logic [9:0] h_count,
  output logic [8:0] v_count,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       frame_start
);

  localparam int H_TOT = seg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = seg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [3:0] div, div_nxt;
  logic [9:0] hc, hc_nxt;
  logic [9:0] vc, vc_nxt;
  logic       tick_nxt, wrap_nxt;
  logic       hs_nxt, vs_nxt, de_nxt;
  logic [8:0] vcount_nxt;
  logic       hs_r, vs_r, de_r;

  always_comb begin
    tick_nxt = (div == DIV_LAST);
    div_nxt  = tick_nxt ? 4'd0 : div + 4'd1;
    hc_nxt   = hc;
    vc_nxt   = vc;
    wrap_nxt = 1'b0;
    if (tick_nxt) begin
      if (hc == H_LAST) begin
        hc_nxt = 10'd0;
        if (vc == V_LAST) begin
          vc_nxt   = 10'd0;
          wrap_nxt = 1'b1;
        end else begin
          vc_nxt = vc + 10'd1;
        end
      end else begin
        hc_nxt = hc + 10'd1;
      end
    end
  end

  // Decode from the next-state position so registered outputs match h_count/v_count.
  always_comb begin
    hs_nxt     = !((hc_nxt >= HS_FIRST) && (hc_nxt <= HS_LAST));
    vs_nxt     = !((vc_nxt >= VS_FIRST) && (vc_nxt <= VS_LAST));
    de_nxt     = (hc_nxt < H_ACT) && (vc_nxt < V_ACT);
    vcount_nxt = (vc_nxt < V_ACT) ? vc_nxt[8:0] : V_BLANK_CODE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div         <= 4'd0;
      pix_tick    <= 1'b0;
      frame_start <= 1'b0;
      hc          <= 10'd0;
      vc          <= 10'd0;
      v_count     <= 9'd0;
      hs_r        <= 1'b1;
      vs_r        <= 1'b1;
      de_r        <= 1'b0;
    end else begin
      div         <= div_nxt;
      pix_tick    <= tick_nxt;
      frame_start <= wrap_nxt;
      hc          <= hc_nxt;
      vc          <= vc_nxt;
      if (tick_nxt) begin
        v_count <= vcount_nxt;
        hs_r    <= hs_nxt;
        vs_r    <= vs_nxt;
        de_r    <= de_nxt;
      end
    end
  end

  assign h_count = hc;

`ifdef VGA_TIMING_ALIGN_EN
  vga_sync_delay #(
    .DEPTH  (ALIGN_LAT),
    .WIDTH  (3),
    .RST_VAL(3'b110)
  ) u_sync_delay (
    .clk (clk),
    .rst (rst),
    .din ({hs_r, vs_r, de_r}),
    .dout({hsync, vsync, de})
  );
`else
  assign hsync = hs_r;
  assign vsync = vs_r;
  assign de    = de_r;
`endif

endmodule
